// File: rtl/pe_run_seq_pkg.sv
// pe_run_seq_pkg: shared state encoding and default sizing for the PE run sequencer
package pe_run_seq_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    REPORT    = 2'd3
  } state_t;
  localparam int CNT_W_DEF       = 16;
  localparam int WDOG_CYCLES_DEF = 65535;
endpackage

// File: rtl/pe_run_seq_wdog.sv
// pe_run_seq_wdog: load-on-clear saturating cycle counter that pulses expire on its last counted cycle
module pe_run_seq_wdog
  import pe_run_seq_pkg::*;
#(
  parameter int LIMIT = WDOG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  // expire fires during the LIMIT-th enabled cycle so the caller leaves after exactly LIMIT cycles
  assign expire = en && (cnt == W'(LIMIT - 1));
  // count enabled cycles, holding at LIMIT
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pe_run_sequencer.sv
// pe_run_sequencer: fans one host start out to PE core and ActUnit, returns one done; optional watchdog via PE_RUN_SEQ_WATCHDOG_EN
module pe_run_sequencer
  import pe_run_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_msg,
  input  logic             start_val,
  output logic             start_rdy,
  output logic             pe_start_msg,
  output logic             pe_start_val,
  input  logic             pe_start_rdy,
  output logic             act_start_msg,
  output logic             act_start_val,
  input  logic             act_start_rdy,
  input  logic             act_done_msg,
  input  logic             act_done_val,
  output logic             act_done_rdy,
  output logic             done_msg,
  output logic             done_val,
  input  logic             done_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] run_count,
  output logic             timeout
);
  state_t state_q, state_d;
  logic msg_q, done_msg_q, pe_sent, act_sent, wdog_expire;
  assign pe_start_msg  = msg_q;
  assign act_start_msg = msg_q;
  assign done_msg      = done_msg_q;
  assign busy          = state_q != IDLE;
`ifdef PE_RUN_SEQ_WATCHDOG_EN
  logic wdog_clr, wdog_en;
  assign wdog_clr = state_q == ISSUE && state_d == WAIT_DONE;
  assign wdog_en  = state_q == WAIT_DONE;
  pe_run_seq_wdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(wdog_clr),
    .en(wdog_en),
    .expire(wdog_expire)
  );
`else
  logic unused_wdog;
  assign unused_wdog = |WDOG_CYCLES;
  assign wdog_expire = 1'b0;
`endif
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and handshake outputs decoded from registered state and sent flags
  always_comb begin
    state_d       = state_q;
    start_rdy     = 1'b0;
    pe_start_val  = 1'b0;
    act_start_val = 1'b0;
    act_done_rdy  = 1'b0;
    done_val      = 1'b0;
    case (state_q)
      IDLE: begin
        start_rdy = 1'b1;
        state_d   = start_val ? ISSUE : IDLE;
      end
      ISSUE: begin
        pe_start_val  = !pe_sent;
        act_start_val = !act_sent;
        state_d = ((pe_sent || pe_start_rdy) && (act_sent || act_start_rdy)) ? WAIT_DONE : ISSUE;
      end
      WAIT_DONE: begin
        act_done_rdy = 1'b1;
        state_d = (act_done_val || wdog_expire) ? REPORT : WAIT_DONE;
      end
      default: begin
        done_val = 1'b1;
        state_d  = done_rdy ? IDLE : REPORT;
      end
    endcase
  end
  // run payloads, per-channel sent flags, completion counter and timeout flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      msg_q      <= 1'b0;
      done_msg_q <= 1'b0;
      pe_sent    <= 1'b0;
      act_sent   <= 1'b0;
      run_count  <= '0;
      timeout    <= 1'b0;
    end else begin
      if (start_val && start_rdy) begin
        msg_q    <= start_msg;
        pe_sent  <= 1'b0;
        act_sent <= 1'b0;
      end
      if (pe_start_val && pe_start_rdy) pe_sent <= 1'b1;
      if (act_start_val && act_start_rdy) act_sent <= 1'b1;
      if (act_done_val && act_done_rdy) done_msg_q <= act_done_msg;
      else if (wdog_expire) begin
        done_msg_q <= 1'b0;
        timeout    <= 1'b1;
      end
      if (done_val && done_rdy) begin
        run_count <= run_count + 1'b1;
        timeout   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pe_run_sequencer.sv
// tb_pe_run_sequencer: table-driven directed checks plus hand sequences for back-pressure, reset and watchdog
module tb_pe_run_sequencer;
  logic clk = 1'b0;
  logic rst, start_msg, start_val, start_rdy;
  logic pe_start_msg, pe_start_val, pe_start_rdy;
  logic act_start_msg, act_start_val, act_start_rdy;
  logic act_done_msg, act_done_val, act_done_rdy;
  logic done_msg, done_val, done_rdy, busy, timeout;
  logic [15:0] run_count;
  int checks = 0;
  int failures = 0;
  int beats;

  always #5 clk = ~clk;

  pe_run_sequencer #(.CNT_W(16), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .start_msg(start_msg), .start_val(start_val), .start_rdy(start_rdy),
    .pe_start_msg(pe_start_msg), .pe_start_val(pe_start_val), .pe_start_rdy(pe_start_rdy),
    .act_start_msg(act_start_msg), .act_start_val(act_start_val), .act_start_rdy(act_start_rdy),
    .act_done_msg(act_done_msg), .act_done_val(act_done_val), .act_done_rdy(act_done_rdy),
    .done_msg(done_msg), .done_val(done_val), .done_rdy(done_rdy),
    .busy(busy), .run_count(run_count), .timeout(timeout)
  );

  // in: rst start_val start_msg pe_rdy act_rdy act_done_val act_done_msg done_rdy
  // e:  start_rdy pe_val act_val msg act_done_rdy done_val done_msg busy timeout
  typedef struct packed {
    logic [7:0]  in;
    logic [8:0]  e;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl [18];

  function automatic vec_t mk(input logic [7:0] i, input logic [8:0] e, input logic [15:0] c);
    vec_t v;
    v.in = i;
    v.e = e;
    v.cnt = c;
    return v;
  endfunction

  function automatic logic [25:0] obs();
    return {start_rdy, pe_start_val, act_start_val, pe_start_msg, act_start_msg,
            act_done_rdy, done_val, done_msg, busy, timeout, run_count};
  endfunction

  task automatic chk(input string n, input logic [25:0] a, input logic [25:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic cyc(input logic [7:0] v);
    @(negedge clk);
    {rst, start_val, start_msg, pe_start_rdy, act_start_rdy, act_done_val, act_done_msg, done_rdy} = v;
    #1;
  endtask

  initial begin
    tbl[0]  = mk(8'b11111001, 9'b100000000, 16'd0);
    tbl[1]  = mk(8'b10011001, 9'b011100010, 16'd0);
    tbl[2]  = mk(8'b10011001, 9'b000110010, 16'd0);
    tbl[3]  = mk(8'b10011001, 9'b000110010, 16'd0);
    tbl[4]  = mk(8'b10011111, 9'b000110010, 16'd0);
    tbl[5]  = mk(8'b10011001, 9'b000101110, 16'd0);
    tbl[6]  = mk(8'b10011001, 9'b100100100, 16'd1);
    tbl[7]  = mk(8'b11010001, 9'b100100100, 16'd1);
    tbl[8]  = mk(8'b10010001, 9'b011000110, 16'd1);
    tbl[9]  = mk(8'b10010001, 9'b001000110, 16'd1);
    tbl[10] = mk(8'b10010001, 9'b001000110, 16'd1);
    tbl[11] = mk(8'b10010001, 9'b001000110, 16'd1);
    tbl[12] = mk(8'b10010001, 9'b001000110, 16'd1);
    tbl[13] = mk(8'b10011001, 9'b001000110, 16'd1);
    tbl[14] = mk(8'b10011101, 9'b000010110, 16'd1);
    tbl[15] = mk(8'b10011000, 9'b000001010, 16'd1);
    tbl[16] = mk(8'b10011111, 9'b000001010, 16'd1);
    tbl[17] = mk(8'b10000000, 9'b100000000, 16'd2);
    cyc(8'b00000000);
    cyc(8'b00000000);
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].in);
      chk($sformatf("vec%0d", i), obs(),
          {tbl[i].e[8:5], tbl[i].e[5], tbl[i].e[4:0], tbl[i].cnt});
    end
    beats = 0;
    for (int i = 0; i < 12; i++) begin
      int ph;
      ph = i % 4;
      cyc(8'b11111111);
      if (pe_start_val && pe_start_rdy) beats++;
      chk($sformatf("held%0d", i),
          26'({start_rdy, pe_start_val, act_start_val, act_done_rdy, done_val, busy, run_count}),
          26'({ph == 0, ph == 1, ph == 1, ph == 2, ph == 3, ph != 0, 16'(2 + i / 4)}));
    end
    chk("held_pe_beats", 26'(beats), 26'd3);
    cyc(8'b11111110);
    chk("rep_start", 26'({start_rdy, busy, run_count}), 26'({2'b10, 16'd5}));
    cyc(8'b10011110);
    cyc(8'b10011110);
    for (int k = 0; k < 10; k++) begin
      cyc(8'b10011110);
      chk($sformatf("stall%0d", k),
          26'({start_rdy, act_done_rdy, done_val, done_msg, busy, run_count}),
          26'({5'b00111, 16'd5}));
    end
    cyc(8'b10011111);
    chk("stall_hs", 26'({done_val, done_msg, run_count}), 26'({2'b11, 16'd5}));
    cyc(8'b10000000);
    chk("stall_after", 26'({start_rdy, done_val, busy, run_count}), 26'({3'b100, 16'd6}));
    for (int k = 0; k < 4; k++) cyc(8'b11111111);
    cyc(8'b11100000);
    chk("pre_rst", 26'({start_rdy, run_count}), 26'({1'b1, 16'd7}));
    cyc(8'b00000000);
    chk("mid_issue", 26'({pe_start_val, act_start_val, busy, run_count}), 26'({3'b111, 16'd7}));
    cyc(8'b10000000);
    chk("post_rst", obs(), {10'b1000000000, 16'd0});
`ifdef PE_RUN_SEQ_WATCHDOG_EN
    cyc(8'b11111000);
    cyc(8'b10011000);
    chk("wd_issue", 26'({pe_start_val, act_start_val}), 26'b11);
    for (int k = 0; k < 8; k++) begin
      cyc(8'b10011000);
      chk($sformatf("wd_wait%0d", k), 26'({act_done_rdy, done_val, timeout}), 26'b100);
    end
    cyc(8'b10011000);
    chk("wd_report", 26'({done_val, done_msg, timeout, act_done_rdy}), 26'b1010);
    cyc(8'b10011001);
    chk("wd_hs", 26'({done_val, timeout, run_count}), 26'({2'b11, 16'd0}));
    cyc(8'b10000000);
    chk("wd_clear", 26'({start_rdy, timeout, run_count}), 26'({2'b10, 16'd1}));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
